light_conflict_monitor: RTL and testbench
=========================================

# light_conflict_monitor

Safety stage directly downstream of the traffic light controller. It samples the four approach light codes (M1, M2, MT, SR) every clock, checks encoding, cross-approach conflicts and per-approach sequencing, and forwards them to the lamp drivers one cycle later. On a violation it latches a fault, records the first cause, and forces all approaches to flashing red until software clears it.

## Interface
Parameters:
- MIN_AMBER, 3: minimum consecutive amber cycles before an approach may leave amber.
- FAULT_PERSIST, 1: consecutive violating cycles required to latch a fault (1..15).
- STARTUP_CYC, 4: all-red hold cycles after reset or fault clear (1..15).
- FLASH_HALF, 1: cycles per half-period of the fault flash (1..15).

Ports:
- clk  in  1  system clock; one controller count per cycle.
- rst  in  1  reset; synchronous, active-high.
- M1_in, M2_in, MT_in, SR_in  in  3 each  light codes from the controller: 001 green, 010 amber, 100 red.
- clr_fault  in  1  request to leave FAULT; acted on only in FAULT.
- M1_out, M2_out, MT_out, SR_out  out  3 each  lamp drive codes, registered.
- fault  out  1  high while in FAULT.
- fault_code  out  3  first cause: 0 none, 1 invalid code, 2 conflict, 3 green→red skip, 4 amber→green, 5 short amber.
- fault_lane  out  2  lane of first cause: 0 M1, 1 M2, 2 MT, 3 SR.

## Operation
- States: STARTUP, NORMAL, FAULT. Reset enters STARTUP.
- STARTUP: all outputs 100. Counts STARTUP_CYC cycles, then moves to NORMAL. No checks run. History registers still track the inputs.
- NORMAL: each output equals the previous cycle's input. Checks are evaluated combinationally on the current inputs versus the history:
  - Invalid: any lane code is not one-hot.
  - Conflict: SR is not red while any of M1, M2 or MT is not red; or M2 and MT are both not red. The reported lane is the lowest index involved.
  - Skip: previous code green, current code red.
  - Amber→green: previous code amber, current code green.
  - Short amber: amber ends (previous amber, current not amber) and the amber run is shorter than MIN_AMBER.
- Priority between simultaneous violations: the lowest fault_code wins, then the lowest lane.
- Persistence: a counter increments on each violating cycle and clears on any clean cycle. When it reaches FAULT_PERSIST, the block enters FAULT and latches fault_code/fault_lane from that cycle.
- FAULT:
  - All four outputs alternate 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, starting with 100.
  - Further violations do not change fault_code or fault_lane.
  - clr_fault moves to STARTUP. fault_code and fault_lane return to 0 on that transition.
- History: per lane, a previous-code register and an amber run counter.
  - Amber run counter: 0 on any non-amber cycle, +1 on each amber cycle, saturating at MIN_AMBER.
  - History updates every cycle in all states.
  - On reset, previous codes are 100 and run counters are 0.

## Timing
- Reset values: all outputs 100, fault 0, fault_code 0, fault_lane 0, state STARTUP, flash phase on.
- rst dominates clr_fault and every other input.
- STARTUP lasts exactly STARTUP_CYC cycles after the reset cycle. The first checked input is sampled in the first NORMAL cycle.
- NORMAL pass-through latency: 1 cycle.
- Fault response with FAULT_PERSIST=1: a violation on input cycle N gives fault=1 and outputs 100 from cycle N+1. The violating code never reaches the outputs.
- Fault response with FAULT_PERSIST=P: the first P-1 violating codes pass through to the outputs.
- A violation in the same cycle as clr_fault while in NORMAL latches the fault; clr_fault is ignored outside FAULT.
- clr_fault in FAULT: the first STARTUP cycle follows on the next clock, with fault=0.
- The flash counter restarts on every entry to FAULT.

## Test plan
- Controller sequence S1→S6, run twice after reset: fault stays 0; after STARTUP_CYC=4 all-red cycles, outputs equal the inputs delayed by 1 cycle.
- M2_in=001 and MT_in=001 in the same cycle: next cycle fault=1, code 2, lane 1, outputs 100; then 000 and 100 alternate on each following cycle.
- MT_in green then red directly: code 3, lane 2. Separately, SR_in amber for 2 cycles then red: code 5, lane 3.
- M1_in=011 together with an M2/MT conflict in the same cycle: code 1, lane 0 (priority check).
- FAULT_PERSIST=3 with a violation held 2 cycles, then clean: no fault. Held 3 cycles: fault latches after the 3rd.
- clr_fault during FAULT: 4 all-red cycles, then pass-through resumes. Separately, rst mid-FAULT: next cycle all reset values.

Source files
------------

// File: rtl/light_conflict_monitor_if.sv
// Light-code bus between the traffic light controller and the conflict monitor.
// The controller side is the master; the monitor is the slave.
interface light_conflict_monitor_if;
    logic [2:0] M1_in;
    logic [2:0] M2_in;
    logic [2:0] MT_in;
    logic [2:0] SR_in;
    logic       clr_fault;
    logic [2:0] M1_out;
    logic [2:0] M2_out;
    logic [2:0] MT_out;
    logic [2:0] SR_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_lane;

    modport master (
        output M1_in, M2_in, MT_in, SR_in, clr_fault,
        input  M1_out, M2_out, MT_out, SR_out, fault, fault_code, fault_lane
    );

    modport slave (
        input  M1_in, M2_in, MT_in, SR_in, clr_fault,
        output M1_out, M2_out, MT_out, SR_out, fault, fault_code, fault_lane
    );
endinterface

// File: rtl/light_conflict_monitor.sv
// Safety monitor between the light controller and the lamp drivers: checks encoding,
// cross-lane conflicts and per-lane sequencing, and forces flashing red on a fault.
module light_conflict_monitor #(
    parameter int MIN_AMBER     = 3,
    parameter int FAULT_PERSIST = 1,
    parameter int STARTUP_CYC   = 4,
    parameter int FLASH_HALF    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    light_conflict_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_NORMAL  = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    localparam logic [2:0] C_GREEN = 3'b001;
    localparam logic [2:0] C_AMBER = 3'b010;
    localparam logic [2:0] C_RED   = 3'b100;
    localparam logic [2:0] C_DARK  = 3'b000;

    localparam int              RUN_W         = (MIN_AMBER < 1) ? 1 : $clog2(MIN_AMBER + 1);
    localparam logic [RUN_W-1:0] MIN_AMBER_V  = RUN_W'(MIN_AMBER);
    localparam logic [3:0]      STARTUP_LAST  = 4'(STARTUP_CYC - 1);
    localparam logic [3:0]      PERSIST_LAST  = 4'(FAULT_PERSIST - 1);
    localparam logic [3:0]      FLASH_LAST    = 4'(FLASH_HALF - 1);

    function automatic logic is_onehot(input logic [2:0] c);
        return (c == C_GREEN) || (c == C_AMBER) || (c == C_RED);
    endfunction

    // Table is five 4-bit lane groups ordered by fault code; the lowest set bit wins.
    function automatic logic [5:0] pick_first(input logic [19:0] tab);
        logic [5:0] r;
        r = 6'd0;
        for (int i = 19; i >= 0; i--) begin
            if (tab[i]) begin
                r = {1'b1, 3'(i / 4 + 1), 2'(i % 4)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_e           state_q,     state_d;
    logic [3:0]       start_cnt_q, start_cnt_d;
    logic [3:0]       pers_q,      pers_d;
    logic [3:0]       flash_cnt_q, flash_cnt_d;
    logic             flash_on_q,  flash_on_d;
    logic             fault_q,     fault_d;
    logic [2:0]       fcode_q,     fcode_d;
    logic [1:0]       flane_q,     flane_d;
    logic [2:0]       out_q  [4];
    logic [2:0]       out_d  [4];
    logic [2:0]       prev_q [4];
    logic [2:0]       prev_d [4];
    logic [RUN_W-1:0] run_q  [4];
    logic [RUN_W-1:0] run_d  [4];

    logic [2:0] in_s [4];
    logic [3:0] inv_s;
    logic [3:0] skip_s;
    logic [3:0] a2g_s;
    logic [3:0] short_s;
    logic [3:0] nr_s;
    logic [3:0] cfl_s;
    logic       sr_rule_s;
    logic       mm_rule_s;
    logic       conflict_s;
    logic [5:0] pick_s;
    logic       any_viol_s;
    logic [2:0] viol_code_s;
    logic [1:0] viol_lane_s;

    assign in_s[0] = bus.M1_in;
    assign in_s[1] = bus.M2_in;
    assign in_s[2] = bus.MT_in;
    assign in_s[3] = bus.SR_in;

    // Per-lane encoding and sequencing checks against the history registers.
    always_comb begin
        inv_s   = 4'b0000;
        skip_s  = 4'b0000;
        a2g_s   = 4'b0000;
        short_s = 4'b0000;
        nr_s    = 4'b0000;
        for (int l = 0; l < 4; l++) begin
            inv_s[l]   = !is_onehot(in_s[l]);
            nr_s[l]    = (in_s[l] != C_RED);
            skip_s[l]  = (prev_q[l] == C_GREEN) && (in_s[l] == C_RED);
            a2g_s[l]   = (prev_q[l] == C_AMBER) && (in_s[l] == C_GREEN);
            short_s[l] = (prev_q[l] == C_AMBER) && (in_s[l] != C_AMBER) && (run_q[l] < MIN_AMBER_V);
        end
    end

    // A lane is flagged for conflict only when it takes part in a violated pairing.
    assign sr_rule_s  = nr_s[3] & (|nr_s[2:0]);
    assign mm_rule_s  = nr_s[1] & nr_s[2];
    assign conflict_s = sr_rule_s | mm_rule_s;
    assign cfl_s      = {sr_rule_s, conflict_s & nr_s[2], conflict_s & nr_s[1], sr_rule_s & nr_s[0]};

    assign pick_s      = pick_first({short_s, a2g_s, skip_s, cfl_s, inv_s});
    assign any_viol_s  = pick_s[5];
    assign viol_code_s = pick_s[4:2];
    assign viol_lane_s = pick_s[1:0];

    // History follows the raw inputs in every state; the amber run saturates.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            prev_d[l] = in_s[l];
            if (in_s[l] == C_AMBER) begin
                run_d[l] = (run_q[l] == MIN_AMBER_V) ? run_q[l] : run_q[l] + RUN_W'(1);
            end else begin
                run_d[l] = '0;
            end
        end
    end

    // Mode sequencing, fault latching and lamp drive selection.
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        pers_d      = pers_q;
        flash_cnt_d = flash_cnt_q;
        flash_on_d  = flash_on_q;
        fault_d     = fault_q;
        fcode_d     = fcode_q;
        flane_d     = flane_q;
        for (int l = 0; l < 4; l++) begin
            out_d[l] = C_RED;
        end

        case (state_q)
            ST_STARTUP: begin
                pers_d = 4'd0;
                if (start_cnt_q == STARTUP_LAST) begin
                    state_d     = ST_NORMAL;
                    start_cnt_d = 4'd0;
                end else begin
                    start_cnt_d = start_cnt_q + 4'd1;
                end
            end
            ST_NORMAL: begin
                if (any_viol_s && (pers_q == PERSIST_LAST)) begin
                    state_d     = ST_FAULT;
                    pers_d      = 4'd0;
                    fault_d     = 1'b1;
                    fcode_d     = viol_code_s;
                    flane_d     = viol_lane_s;
                    flash_on_d  = 1'b1;
                    flash_cnt_d = 4'd0;
                end else begin
                    pers_d = any_viol_s ? pers_q + 4'd1 : 4'd0;
                    for (int l = 0; l < 4; l++) begin
                        out_d[l] = in_s[l];
                    end
                end
            end
            ST_FAULT: begin
                if (bus.clr_fault) begin
                    state_d     = ST_STARTUP;
                    start_cnt_d = 4'd0;
                    fault_d     = 1'b0;
                    fcode_d     = 3'd0;
                    flane_d     = 2'd0;
                    flash_on_d  = 1'b1;
                    flash_cnt_d = 4'd0;
                end else begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_on_d  = !flash_on_q;
                        flash_cnt_d = 4'd0;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 4'd1;
                    end
                    for (int l = 0; l < 4; l++) begin
                        out_d[l] = flash_on_d ? C_RED : C_DARK;
                    end
                end
            end
            default: begin
                state_d     = ST_STARTUP;
                start_cnt_d = 4'd0;
                pers_d      = 4'd0;
            end
        endcase
    end

    // State, history and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_STARTUP;
            start_cnt_q <= 4'd0;
            pers_q      <= 4'd0;
            flash_cnt_q <= 4'd0;
            flash_on_q  <= 1'b1;
            fault_q     <= 1'b0;
            fcode_q     <= 3'd0;
            flane_q     <= 2'd0;
            for (int l = 0; l < 4; l++) begin
                out_q[l]  <= C_RED;
                prev_q[l] <= C_RED;
                run_q[l]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            pers_q      <= pers_d;
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            fault_q     <= fault_d;
            fcode_q     <= fcode_d;
            flane_q     <= flane_d;
            for (int l = 0; l < 4; l++) begin
                out_q[l]  <= out_d[l];
                prev_q[l] <= prev_d[l];
                run_q[l]  <= run_d[l];
            end
        end
    end

    assign bus.M1_out     = out_q[0];
    assign bus.M2_out     = out_q[1];
    assign bus.MT_out     = out_q[2];
    assign bus.SR_out     = out_q[3];
    assign bus.fault      = fault_q;
    assign bus.fault_code = fcode_q;
    assign bus.fault_lane = flane_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Bench for light_conflict_monitor: two instances (fault persistence 1 and 3) share one
// stimulus stream and are compared every cycle against a rule-level reference model.
module tb_light_conflict_monitor;

    localparam int MIN_AMBER   = 3;
    localparam int STARTUP_CYC = 4;
    localparam int FLASH_HALF  = 1;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] A = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [11:0] ALLRED = {R, R, R, R};

    localparam int M_START  = 0;
    localparam int M_NORMAL = 1;
    localparam int M_FAULT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    light_conflict_monitor_if bus1 ();
    light_conflict_monitor_if bus3 ();

    light_conflict_monitor #(.MIN_AMBER(MIN_AMBER), .FAULT_PERSIST(1),
        .STARTUP_CYC(STARTUP_CYC), .FLASH_HALF(FLASH_HALF))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    light_conflict_monitor #(.MIN_AMBER(MIN_AMBER), .FAULT_PERSIST(3),
        .STARTUP_CYC(STARTUP_CYC), .FLASH_HALF(FLASH_HALF))
        dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    // Reference model: index 0 models persistence 1, index 1 persistence 3.
    int          mode    [2];
    int          t_start [2];
    int          vrun    [2];
    int          fage    [2];
    logic [11:0] e_out   [2];
    logic        e_fault [2];
    logic [2:0]  e_code  [2];
    logic [1:0]  e_lane  [2];
    logic [11:0] hist [$];

    function automatic logic [11:0] w(input logic [2:0] m1, input logic [2:0] m2,
                                      input logic [2:0] mt, input logic [2:0] sr);
        return {sr, mt, m2, m1};
    endfunction

    function automatic logic [2:0] prev_code(input int l);
        logic [11:0] h;
        if (hist.size() == 0) return R;
        h = hist[hist.size() - 1];
        return h[l*3 +: 3];
    endfunction

    function automatic bit amber_short(input int l);
        logic [11:0] h;
        for (int k = 1; k <= MIN_AMBER; k++) begin
            if (hist.size() < k) return 1'b1;
            h = hist[hist.size() - k];
            if (h[l*3 +: 3] != A) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit not_red(input logic [11:0] cur, input int l);
        return cur[l*3 +: 3] != R;
    endfunction

    function automatic bit rule_hit(input int code, input int l, input logic [11:0] cur);
        logic [2:0] c;
        logic [2:0] p;
        bit rule_a;
        bit rule_b;
        c = cur[l*3 +: 3];
        p = prev_code(l);
        rule_a = not_red(cur, 3) && (not_red(cur, 0) || not_red(cur, 1) || not_red(cur, 2));
        rule_b = not_red(cur, 1) && not_red(cur, 2);
        case (code)
            1: return !((c == G) || (c == A) || (c == R));
            2: return (rule_a && ((l == 3) || not_red(cur, l))) || (rule_b && ((l == 1) || (l == 2)));
            3: return (p == G) && (c == R);
            4: return (p == A) && (c == G);
            5: return (p == A) && (c != A) && amber_short(l);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input int m, input logic [11:0] cur, input bit clr, input bit r);
        int  p;
        bit  hit;
        int  hc;
        int  hl;
        p = (m == 0) ? 1 : 3;
        if (r) begin
            mode[m] = M_START; t_start[m] = 0; vrun[m] = 0;
            e_out[m] = ALLRED; e_fault[m] = 1'b0; e_code[m] = 3'd0; e_lane[m] = 2'd0;
        end else if (mode[m] == M_START) begin
            e_out[m] = ALLRED;
            t_start[m]++;
            if (t_start[m] == STARTUP_CYC) begin
                mode[m] = M_NORMAL;
                vrun[m] = 0;
            end
        end else if (mode[m] == M_NORMAL) begin
            hit = 1'b0; hc = 0; hl = 0;
            for (int c = 1; c <= 5; c++) begin
                for (int l = 0; l < 4; l++) begin
                    if (!hit && rule_hit(c, l, cur)) begin
                        hit = 1'b1; hc = c; hl = l;
                    end
                end
            end
            vrun[m] = hit ? vrun[m] + 1 : 0;
            if (hit && (vrun[m] == p)) begin
                mode[m] = M_FAULT; fage[m] = 0;
                e_fault[m] = 1'b1; e_code[m] = 3'(hc); e_lane[m] = 2'(hl);
                e_out[m] = ALLRED;
            end else begin
                e_out[m] = cur;
            end
        end else begin
            if (clr) begin
                mode[m] = M_START; t_start[m] = 0;
                e_fault[m] = 1'b0; e_code[m] = 3'd0; e_lane[m] = 2'd0;
                e_out[m] = ALLRED;
            end else begin
                fage[m]++;
                e_out[m] = (((fage[m] / FLASH_HALF) % 2) == 0) ? ALLRED : 12'd0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at cycle %0d: observed %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive both DUTs, advance the model, then compare full output state.
    task automatic tick(input logic [11:0] cur, input bit clr, input bit r);
        bus1.M1_in = cur[2:0];  bus1.M2_in = cur[5:3];  bus1.MT_in = cur[8:6];  bus1.SR_in = cur[11:9];
        bus3.M1_in = cur[2:0];  bus3.M2_in = cur[5:3];  bus3.MT_in = cur[8:6];  bus3.SR_in = cur[11:9];
        bus1.clr_fault = clr;
        bus3.clr_fault = clr;
        rst = r;
        model_step(0, cur, clr, r);
        model_step(1, cur, clr, r);
        if (r) hist.delete();
        else begin
            hist.push_back(cur);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("p1_state",
            {14'd0, bus1.SR_out, bus1.MT_out, bus1.M2_out, bus1.M1_out, bus1.fault, bus1.fault_code, bus1.fault_lane},
            {14'd0, e_out[0], e_fault[0], e_code[0], e_lane[0]});
        chk("p3_state",
            {14'd0, bus3.SR_out, bus3.MT_out, bus3.M2_out, bus3.M1_out, bus3.fault, bus3.fault_code, bus3.fault_lane},
            {14'd0, e_out[1], e_fault[1], e_code[1], e_lane[1]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(ALLRED, 1'b0, 1'b0);
    endtask

    task automatic restart();
        tick(ALLRED, 1'b0, 1'b1);
        idle(STARTUP_CYC + 1);
    endtask

    logic [11:0] seq  [6];
    int          hold [6];
    logic [11:0] cur;
    logic [2:0]  lc;
    bit          rclr;
    bit          rrst;

    initial begin
        seq[0] = w(G, G, R, R); hold[0] = 4;
        seq[1] = w(A, A, R, R); hold[1] = 3;
        seq[2] = w(R, R, G, R); hold[2] = 4;
        seq[3] = w(R, R, A, R); hold[3] = 3;
        seq[4] = w(R, R, R, G); hold[4] = 4;
        seq[5] = w(R, R, R, A); hold[5] = 3;

        tick(ALLRED, 1'b0, 1'b1);
        tick(ALLRED, 1'b0, 1'b1);
        chk("reset_vals", {bus1.SR_out, bus1.MT_out, bus1.M2_out, bus1.M1_out, bus1.fault, bus1.fault_code, bus1.fault_lane},
            {ALLRED, 1'b0, 3'd0, 2'd0});

        // Legal controller sequence, twice.
        for (int rep = 0; rep < 2; rep++)
            for (int s = 0; s < 6; s++)
                for (int h = 0; h < hold[s]; h++) tick(seq[s], 1'b0, 1'b0);
        chk("seq_no_fault_p1", {31'd0, bus1.fault}, 32'd0);
        chk("seq_no_fault_p3", {31'd0, bus3.fault}, 32'd0);

        // M2/MT conflict, flash pattern, then clear and restart.
        restart();
        tick(w(R, G, G, R), 1'b0, 1'b0);
        chk("cfl_flags", {26'd0, bus1.fault, bus1.fault_code, bus1.fault_lane}, {26'd0, 1'b1, 3'd2, 2'd1});
        chk("cfl_red", {20'd0, bus1.SR_out, bus1.MT_out, bus1.M2_out, bus1.M1_out}, {20'd0, ALLRED});
        idle(1);
        chk("flash_off", {20'd0, bus1.SR_out, bus1.MT_out, bus1.M2_out, bus1.M1_out}, 32'd0);
        idle(1);
        chk("flash_on", {20'd0, bus1.SR_out, bus1.MT_out, bus1.M2_out, bus1.M1_out}, {20'd0, ALLRED});
        chk("cfl_p3_clean", {31'd0, bus3.fault}, 32'd0);
        tick(ALLRED, 1'b1, 1'b0);
        chk("clr_fault_low", {26'd0, bus1.fault, bus1.fault_code, bus1.fault_lane}, 32'd0);
        idle(STARTUP_CYC);
        tick(w(G, R, R, R), 1'b0, 1'b0);
        chk("resume_pass", {29'd0, bus1.M1_out}, {29'd0, G});

        // Green to red skip on MT.
        restart();
        tick(w(R, R, G, R), 1'b0, 1'b0);
        tick(ALLRED, 1'b0, 1'b0);
        chk("skip_flags", {26'd0, bus1.fault, bus1.fault_code, bus1.fault_lane}, {26'd0, 1'b1, 3'd3, 2'd2});

        // Two-cycle amber on SR.
        restart();
        tick(w(R, R, R, A), 1'b0, 1'b0);
        tick(w(R, R, R, A), 1'b0, 1'b0);
        tick(ALLRED, 1'b0, 1'b0);
        chk("short_flags", {26'd0, bus1.fault, bus1.fault_code, bus1.fault_lane}, {26'd0, 1'b1, 3'd5, 2'd3});

        // Invalid code outranks a simultaneous conflict.
        restart();
        tick(w(3'b011, G, G, R), 1'b0, 1'b0);
        chk("prio_flags", {26'd0, bus1.fault, bus1.fault_code, bus1.fault_lane}, {26'd0, 1'b1, 3'd1, 2'd0});

        // Persistence 3: two violating cycles are tolerated, three latch.
        restart();
        tick(w(3'b111, R, R, R), 1'b0, 1'b0);
        chk("persist_pass", {29'd0, bus3.M1_out}, 32'd7);
        tick(w(3'b111, R, R, R), 1'b0, 1'b0);
        idle(2);
        chk("persist_2_clean", {31'd0, bus3.fault}, 32'd0);
        tick(w(3'b111, R, R, R), 1'b0, 1'b0);
        tick(w(3'b111, R, R, R), 1'b0, 1'b0);
        chk("persist_2_held", {31'd0, bus3.fault}, 32'd0);
        tick(w(3'b111, R, R, R), 1'b0, 1'b0);
        chk("persist_3_flags", {26'd0, bus3.fault, bus3.fault_code, bus3.fault_lane}, {26'd0, 1'b1, 3'd1, 2'd0});

        // Reset in the middle of a fault.
        idle(2);
        tick(ALLRED, 1'b1, 1'b1);
        chk("rst_in_fault", {bus3.SR_out, bus3.MT_out, bus3.M2_out, bus3.M1_out, bus3.fault, bus3.fault_code, bus3.fault_lane},
            {ALLRED, 1'b0, 3'd0, 2'd0});

        // Randomised sticky lane codes with occasional invalid codes, clears and resets.
        idle(STARTUP_CYC + 1);
        cur = ALLRED;
        for (int i = 0; i < 600; i++) begin
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 15) == 0) lc = 3'($urandom);
                    else begin
                        case ($urandom_range(0, 2))
                            0: lc = G;
                            1: lc = A;
                            default: lc = R;
                        endcase
                    end
                    cur[l*3 +: 3] = lc;
                end
            end
            rclr = ($urandom_range(0, 7) == 0);
            rrst = ($urandom_range(0, 99) == 0);
            tick(cur, rclr, rrst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
